bit_serial_alu_seq: RTL

- Sequencer that drives the one-bit ALU slice serially, LSB first, one bit per clock.
- Accepts a full-width operation request, presents a/b/cin/less/sub/op to the slice each cycle, and feeds the slice carry-out back as the next carry-in.
- Collects the slice result bits into a WIDTH-bit result.
- Used in the area-reduced datapath as the initiator side of the slice interface; the slice stays purely combinational.

---
 rtl/bit_serial_alu_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bit_serial_alu_seq.sv
// Serial sequencer for the one-bit ALU slice: streams operands LSB first and
// assembles the result. Optional overflow capture enabled by BSALU_OVF_EN.
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [3:0]       s_op,
  output logic             s_a,
  output logic             s_b,
  output logic             s_cin,
  output logic             s_less,
  output logic             s_sub,
  input  logic             s_r,
  input  logic             s_cout,
  input  logic             s_set
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] SLT_FIX = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       op_q;
  logic             is_sub;
  logic             is_slt;
  logic [WIDTH-1:0] result_nxt;

  assign is_slt     = (op_q == OP_SLT);
  assign is_sub     = (op_q == OP_SUB) || is_slt;
  assign result_nxt = {s_r, result[WIDTH-1:1]};
  assign ready      = (state == IDLE);
  assign valid      = (state == DONE);

  // s_* are registered: the cycle after acceptance (cnt=0) only loads bit 0,
  // and each later RUN edge captures bit cnt-1 while presenting bit cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= '0;
      result <= '0;
      zero   <= 1'b1;
      s_op   <= '0;
      s_a    <= 1'b0;
      s_b    <= 1'b0;
      s_cin  <= 1'b0;
      s_less <= 1'b0;
      s_sub  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            op_q  <= alu_ctrl;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            result <= result_nxt;
          end
          if (cnt != LAST) begin
            s_a    <= a_sh[0];
            s_b    <= b_sh[0];
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            s_op   <= is_slt ? OP_SUB : op_q;
            s_sub  <= is_sub;
            s_less <= 1'b0;
            s_cin  <= (cnt == '0) ? is_sub : s_cout;
            cnt    <= cnt + 1'b1;
          end else if (is_slt) begin
            s_op   <= OP_SLT;
            s_less <= s_set;
            s_a    <= 1'b0;
            s_b    <= 1'b0;
            s_cin  <= 1'b0;
            s_sub  <= 1'b0;
            state  <= SLT_FIX;
          end else begin
            zero   <= (result_nxt == '0);
            s_op   <= '0;
            s_a    <= 1'b0;
            s_b    <= 1'b0;
            s_cin  <= 1'b0;
            s_sub  <= 1'b0;
            state  <= DONE;
          end
        end
        SLT_FIX: begin
          result <= {{(WIDTH-1){1'b0}}, s_r};
          zero   <= ~s_r;
          s_op   <= '0;
          s_less <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BSALU_OVF_EN
  // s_cin still holds the MSB carry-in on the final RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (state == RUN && cnt == LAST) begin
      overflow <= ((op_q == OP_ADD) || (op_q == OP_SUB)) & (s_cin ^ s_cout);
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
